// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, h/v counters, registered
// sync/visible/frame-tick decode, and a one-clk colour/sync output stage.
module vga_timing_gen #(
  parameter int unsigned pA     = 10,
  parameter int unsigned cA     = 4,
  parameter int unsigned DIV    = 2,
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [pA-1:0]        pix_x,
  output logic [pA-1:0]        pix_y,
  output logic                 pix_v,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 img_return,
  input  logic [2:0][cA-1:0]   color_in,
  output logic [cA-1:0]        vga_r,
  output logic [cA-1:0]        vga_g,
  output logic [cA-1:0]        vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_VIS + H_FP;
  localparam int unsigned HS_END  = H_VIS + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_VIS + V_FP;
  localparam int unsigned VS_END  = V_VIS + V_FP + V_SYNC;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic          pe;
  logic [pA-1:0] h;
  logic [pA-1:0] v;
  logic [pA-1:0] h_nxt;
  logic [pA-1:0] v_nxt;

  assign pe    = (pre == PW'(DIV - 1));
  assign pix_x = h;
  assign pix_y = v;

  // Next raster position; decoded outputs are registered from these values so
  // that every output describes the same (h,v) as the counters in each cycle.
  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (pe) begin
      if (h == pA'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (v == pA'(V_TOTAL - 1)) ? '0 : v + pA'(1);
      end else begin
        h_nxt = h + pA'(1);
      end
    end
  end

  // Prescaler, counters and registered timing decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre        <= '0;
      h          <= pA'(H_TOTAL - 1);
      v          <= pA'(V_TOTAL - 1);
      pix_v      <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      img_return <= 1'b0;
    end else begin
      pre        <= pe ? '0 : pre + PW'(1);
      h          <= h_nxt;
      v          <= v_nxt;
      pix_v      <= (h_nxt < pA'(H_VIS)) && (v_nxt < pA'(V_VIS));
      hsync      <= !((h_nxt >= pA'(HS_BEG)) && (h_nxt < pA'(HS_END)));
      vsync      <= !((v_nxt >= pA'(VS_BEG)) && (v_nxt < pA'(VS_END)));
      // Only the step onto (0,V_VIS) raises the tick; the following cycle has
      // no pe (DIV>1) or moves to h=1 (DIV=1), so it always lasts one clk.
      img_return <= pe && (h_nxt == '0) && (v_nxt == pA'(V_VIS));
    end
  end

  // Blanked colour and delayed syncs, one clk behind the timing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= pix_v ? color_in[0] : '0;
      vga_g  <= pix_v ? color_in[1] : '0;
      vga_b  <= pix_v ? color_in[2] : '0;
      vga_hs <= hsync;
      vga_vs <= vsync;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter pA, 10: coordinate width in bits.
REQ-002 Parameter cA, 4: colour channel width in bits.
REQ-003 Parameter DIV, 2: clk cycles per pixel; legal values are 1 or more.
REQ-004 Parameters H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal visible, front porch, sync and back porch lengths in pixels; H_TOTAL = sum (800).
REQ-005 Parameters V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33: vertical visible, front porch, sync and back porch lengths in lines; V_TOTAL = sum (525).
REQ-006 clk  input  1: single clock; all state changes on its rising edge.
REQ-007 rst  input  1: asynchronous, active-low reset.
REQ-008 pix_x  output  pA: current horizontal count h.
REQ-009 pix_y  output  pA: current vertical count v.
REQ-010 pix_v  output  1: high when the current (h,v) is in the visible region.
REQ-011 hsync  output  1: active-low horizontal sync, aligned with pix_x.
REQ-012 vsync  output  1: active-low vertical sync, aligned with pix_y.
REQ-013 img_return  output  1: one-clk frame tick at the start of vertical blanking.
REQ-014 color_in  input  cA x [2:0]: renderer colour; index 2 is blue, 1 is green, 0 is red.
REQ-015 vga_r, vga_g, vga_b  output  cA each: registered, blanked pixel colour.
REQ-016 vga_hs, vga_vs  output  1 each: hsync and vsync delayed one clk, aligned with vga_r/g/b.

Function
REQ-017 The prescaler shall count 0..DIV-1, wrapping to 0. The pixel step pe is the clk edge at which prescaler == DIV-1.
REQ-018 On pe, h shall increment; h == H_TOTAL-1 shall wrap to 0. No change occurs without pe.
REQ-019 On pe with h == H_TOTAL-1, v shall increment; v == V_TOTAL-1 shall wrap to 0. Otherwise v holds.
REQ-020 pix_x, pix_y, pix_v, hsync, vsync and img_return shall be registers updated on the same edge as h and v. In every cycle they shall describe the same (h,v) pair, with no combinational decode on the outputs.
REQ-021 pix_v = (h < H_VIS) and (v < V_VIS).
REQ-022 hsync shall be 0 exactly when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751); otherwise 1.
REQ-023 vsync shall be 0 exactly when V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491); otherwise 1.
REQ-024 img_return shall be 1 only during the first clk cycle after the pe that moves (h,v) to (0,V_VIS). It is 1 exactly once per frame, lasts one clk for any DIV, and is otherwise 0.
REQ-025 Colour stage, each clk:
- vga_r = color_in[0], vga_g = color_in[1], vga_b = color_in[2] when pix_v = 1; all three 0 when pix_v = 0.
- vga_hs <= hsync and vga_vs <= vsync, giving one clk latency on all vga_* outputs.
REQ-026 Frame period shall be exactly H_TOTAL*V_TOTAL*DIV clk cycles (840000 at defaults).

Reset
REQ-027 While rst = 0, these values shall be forced asynchronously:
- prescaler = 0; h = H_TOTAL-1; v = V_TOTAL-1.
- pix_x = 799, pix_y = 524, pix_v = 0, hsync = 1, vsync = 1, img_return = 0.
- vga_r/g/b = 0, vga_hs = 1, vga_vs = 1.
REQ-028 After rst deasserts, the DIV-th rising clk edge shall move (h,v) to (0,0) with pix_v = 1.
REQ-029 Asserting rst at any point mid-frame shall abort the frame and restart from REQ-027, with no img_return pulse.

Verification
REQ-030 Reset release, DIV=2 -> pix_x=799 and pix_y=524 for 2 clk, then (0,0) with pix_v=1; pix_x advances every 2 clk.
REQ-031 Run one line -> hsync low for exactly 192 clk starting at pix_x=656; pix_x wraps 799->0 and pix_y increments on the same edge.
REQ-032 Run two full frames -> img_return high for exactly 1 clk per frame, coinciding with (0,480); pulse spacing is 840000 clk; vsync low 3200 clk starting at pix_y=490.
REQ-033 color_in = {4'hA,4'h5,4'h3} held constant -> vga_b=A, vga_g=5, vga_r=3 one clk after pix_v=1; vga_* = 0 one clk after pix_v=0; vga_hs equals hsync delayed by 1 clk.
REQ-034 Assert rst at (h,v)=(300,200) -> all outputs take the REQ-027 values immediately, without waiting for a clk edge; on release, the sequence of REQ-030 repeats.
REQ-035 DIV=1 build -> (h,v) steps every clk; img_return still lasts 1 clk; frame period is 420000 clk.
